// File: rtl/weight_loader.sv
// weight_loader: collects an N x N weight tile row by row, then shifts it into
// a systolic array column-wise (last row first) so that MAC row r ends up with
// tile row r, and finally requests a shadow-to-active swap.
// Optional feature: define WEIGHT_LOADER_AUTO_SWAP_EN to swap automatically
// right after the shift phase instead of waiting for swap_req in HOLD.
module weight_loader #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*DW-1:0] in_row,
  input  logic            swap_req,
  output logic [N*DW-1:0] weight_out,
  output logic            load_weight,
  output logic            swap_weights,
  output logic            tile_ready
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] PREV_IDX = CW'(N - 2);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [CW-1:0]     row_cnt_r, row_cnt_nxt_s;
  logic [CW-1:0]     shift_cnt_r, shift_cnt_nxt_s;
  logic [N*DW-1:0]   buf_r [N];
  logic [N*DW-1:0]   weight_out_r, weight_out_nxt_s;
  logic              load_weight_r, load_weight_nxt_s;
  logic              swap_weights_r, swap_weights_nxt_s;
  logic              tile_ready_r, tile_ready_nxt_s;
  logic              fill_s;
  logic              accept_s;
  logic [CW-1:0]     rd_idx_s;

`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
  logic unused_swap_req_s;
  assign unused_swap_req_s = swap_req;
`endif

  assign fill_s   = (state_r == FILL);
  assign accept_s = fill_s & in_valid;
  // Shift cycle k+1 presents slot N-2-k; slot N-1 goes out straight from in_row.
  assign rd_idx_s = PREV_IDX - shift_cnt_r;

  assign in_ready     = fill_s;
  assign weight_out   = weight_out_r;
  assign load_weight  = load_weight_r;
  assign swap_weights = swap_weights_r;
  assign tile_ready   = tile_ready_r;

  // Next-state and next-output decode for the fill/shift/hold sequencer.
  always_comb begin
    state_nxt_s        = state_r;
    row_cnt_nxt_s      = row_cnt_r;
    shift_cnt_nxt_s    = shift_cnt_r;
    weight_out_nxt_s   = '0;
    load_weight_nxt_s  = 1'b0;
    swap_weights_nxt_s = 1'b0;
    tile_ready_nxt_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          if (row_cnt_r == LAST_IDX) begin
            // Final row bypasses the buffer so the shift starts next cycle.
            state_nxt_s       = SHIFT;
            row_cnt_nxt_s     = '0;
            shift_cnt_nxt_s   = '0;
            weight_out_nxt_s  = in_row;
            load_weight_nxt_s = 1'b1;
          end else begin
            row_cnt_nxt_s = row_cnt_r + 1'b1;
          end
        end else begin
          row_cnt_nxt_s = row_cnt_r;
        end
      end
      SHIFT: begin
        if (shift_cnt_r == LAST_IDX) begin
          shift_cnt_nxt_s = '0;
`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
          state_nxt_s        = FILL;
          swap_weights_nxt_s = 1'b1;
`else
          state_nxt_s      = HOLD;
          tile_ready_nxt_s = 1'b1;
`endif
        end else begin
          shift_cnt_nxt_s   = shift_cnt_r + 1'b1;
          weight_out_nxt_s  = buf_r[rd_idx_s];
          load_weight_nxt_s = 1'b1;
        end
      end
      HOLD: begin
`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
        state_nxt_s = FILL;
`else
        if (swap_req) begin
          state_nxt_s        = FILL;
          swap_weights_nxt_s = 1'b1;
        end else begin
          tile_ready_nxt_s = 1'b1;
        end
`endif
      end
      default: begin
        state_nxt_s     = FILL;
        row_cnt_nxt_s   = '0;
        shift_cnt_nxt_s = '0;
      end
    endcase
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= FILL;
      row_cnt_r      <= '0;
      shift_cnt_r    <= '0;
      weight_out_r   <= '0;
      load_weight_r  <= 1'b0;
      swap_weights_r <= 1'b0;
      tile_ready_r   <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      row_cnt_r      <= row_cnt_nxt_s;
      shift_cnt_r    <= shift_cnt_nxt_s;
      weight_out_r   <= weight_out_nxt_s;
      load_weight_r  <= load_weight_nxt_s;
      swap_weights_r <= swap_weights_nxt_s;
      tile_ready_r   <= tile_ready_nxt_s;
    end
  end

  // Row buffer: written only on an accepted row, never cleared between tiles.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      buf_r[row_cnt_r] <= in_row;
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader (N=4, DW=8). Includes a small
// lane-0 MAC column model (shadow shift chain + active registers).
module tb_weight_loader;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_row;
  logic            swap_req;
  logic [N*DW-1:0] weight_out;
  logic            load_weight;
  logic            swap_weights;
  logic            tile_ready;

  int checks;
  int errors;

  logic [DW-1:0] sh_w  [N];
  logic [DW-1:0] act_w [N];

  weight_loader #(.N(N), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_row       (in_row),
    .swap_req     (swap_req),
    .weight_out   (weight_out),
    .load_weight  (load_weight),
    .swap_weights (swap_weights),
    .tile_ready   (tile_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane-0 MAC column: shadow chain shifts on load_weight, active copies on swap.
  always @(posedge clk) begin
    if (load_weight) begin
      sh_w[0] <= weight_out[DW-1:0];
      for (int r = 1; r < N; r++) sh_w[r] <= sh_w[r-1];
    end
    if (swap_weights) begin
      for (int r = 0; r < N; r++) act_w[r] <= sh_w[r];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the edge that ends the shift phase; completes the swap.
  task automatic finish_tile();
`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
    checks++;
    if (swap_weights !== 1'b1 || in_ready !== 1'b1 || tile_ready !== 1'b0) begin
      errors++;
      $display("FAIL auto_swap: swap=%b in_ready=%b tile_ready=%b, expected 1 1 0", swap_weights, in_ready, tile_ready);
    end
    tick();
`else
    checks++;
    if (tile_ready !== 1'b1 || load_weight !== 1'b0) begin
      errors++;
      $display("FAIL tile_ready: tile_ready=%b load=%b, expected 1 0", tile_ready, load_weight);
    end
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    checks++;
    if (swap_weights !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_pulse: swap=%b in_ready=%b, expected 1 1", swap_weights, in_ready);
    end
    tick();
`endif
    checks++;
    if (swap_weights !== 1'b0) begin
      errors++;
      $display("FAIL swap_width: swap=%b, expected 0", swap_weights);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_row = '0; swap_req = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || weight_out !== 32'h0 || load_weight !== 1'b0 ||
        swap_weights !== 1'b0 || tile_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wo=%h lw=%b sw=%b tr=%b, expected 1 0 0 0 0",
               in_ready, weight_out, load_weight, swap_weights, tile_ready);
    end
  endtask

  task automatic test_reset_mid();
    // Partial fill then reset: the partial tile must be dropped.
    in_valid = 1'b1;
    in_row = 32'hAAAAAAAA; tick();
    in_row = 32'hBBBBBBBB; tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || load_weight !== 1'b0) begin
      errors++;
      $display("FAIL reset_fill: rdy=%b lw=%b, expected 1 0", in_ready, load_weight);
    end
    rst_n = 1'b1;
    // Full fill, one shift cycle, then reset mid-shift.
    for (int i = 0; i < N; i++) begin
      in_row = 32'h01010101 * (i + 1);
      tick();
      if (i < N - 1) begin
        checks++;
        if (load_weight !== 1'b0) begin
          errors++;
          $display("FAIL refill_count row %0d: lw=%b, expected 0", i, load_weight);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (load_weight !== 1'b0 || weight_out !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_shift: lw=%b wo=%h rdy=%b, expected 0 0 1", load_weight, weight_out, in_ready);
    end
    rst_n = 1'b1;
    swap_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (swap_weights !== 1'b0 || tile_ready !== 1'b0 || load_weight !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_swap cyc %0d: sw=%b tr=%b lw=%b, expected 0 0 0", i, swap_weights, tile_ready, load_weight);
      end
    end
    swap_req = 1'b0;
  endtask

  task automatic test_fill_shift();
    logic [N*DW-1:0] rows [N];
    rows[0] = 32'h04030201; rows[1] = 32'h08070605;
    rows[2] = 32'h0C0B0A09; rows[3] = 32'h100F0E0D;
    in_valid = 1'b1;
    swap_req = 1'b1;  // must be ignored while filling and shifting
    for (int i = 0; i < N; i++) begin
      in_row = rows[i];
      tick();
      if (i < N - 1) begin
        checks++;
        if (load_weight !== 1'b0 || swap_weights !== 1'b0) begin
          errors++;
          $display("FAIL fill_quiet row %0d: lw=%b sw=%b, expected 0 0", i, load_weight, swap_weights);
        end
      end
    end
    in_row = 32'hDEADBEEF;  // offered while not ready: must not land in the buffer
    for (int k = 0; k < N; k++) begin
      checks++;
      if (load_weight !== 1'b1 || weight_out !== rows[N-1-k] || swap_weights !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL shift_k%0d: lw=%b wo=%h sw=%b rdy=%b, expected 1 %h 0 0",
                 k, load_weight, weight_out, swap_weights, in_ready, rows[N-1-k]);
      end
      tick();
    end
`ifdef WEIGHT_LOADER_AUTO_SWAP_EN
    swap_req = 1'b0;
    in_valid = 1'b0;
    finish_tile();
`else
    swap_req = 1'b0;
    checks++;
    if (load_weight !== 1'b0 || weight_out !== 32'h0 || tile_ready !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL hold_entry: lw=%b wo=%h tr=%b rdy=%b, expected 0 0 1 0", load_weight, weight_out, tile_ready, in_ready);
    end
    // Hold for 10 cycles with junk offered and no swap request.
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (swap_weights !== 1'b0 || in_ready !== 1'b0 || tile_ready !== 1'b1) begin
        errors++;
        $display("FAIL hold_wait cyc %0d: sw=%b rdy=%b tr=%b, expected 0 0 1", i, swap_weights, in_ready, tile_ready);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut.buf_r[i] !== rows[i]) begin
        errors++;
        $display("FAIL buffer_keep slot %0d: got %h, expected %h", i, dut.buf_r[i], rows[i]);
      end
    end
    in_valid = 1'b0;
    finish_tile();
`endif
    checks++;
    if (act_w[0] !== 8'h01 || act_w[3] !== 8'h0D) begin
      errors++;
      $display("FAIL mac_order: act0=%h act3=%h, expected 01 0d", act_w[0], act_w[3]);
    end
  endtask

  task automatic test_toggle();
    logic [N*DW-1:0] rows [N];
    rows[0] = 32'hA1A1A1A1; rows[1] = 32'hA2A2A2A2;
    rows[2] = 32'hA3A3A3A3; rows[3] = 32'hA4A4A4A4;
    for (int i = 0; i < 2 * N; i++) begin
      in_valid = (i % 2 == 0);
      in_row   = (i % 2 == 0) ? rows[i/2] : 32'h5A5A5A5A;
      tick();
      checks++;
      if (load_weight !== (i >= 2 * N - 2)) begin
        errors++;
        $display("FAIL toggle_lw i=%0d: lw=%b, expected %b", i, load_weight, (i >= 2 * N - 2));
      end
    end
    in_valid = 1'b0;
    checks++;
    if (weight_out !== rows[2]) begin
      errors++;
      $display("FAIL toggle_k1: wo=%h, expected %h", weight_out, rows[2]);
    end
    tick();
    tick();
    checks++;
    if (weight_out !== rows[0] || load_weight !== 1'b1) begin
      errors++;
      $display("FAIL toggle_k3: wo=%h lw=%b, expected %h 1", weight_out, load_weight, rows[0]);
    end
    tick();
    finish_tile();
  endtask

  task automatic test_end_to_end();
    logic [31:0] acc;
    logic [N*DW-1:0] rows [N];
    rows[0] = 32'h00000039; rows[1] = 32'h0000000A;
    rows[2] = 32'h0000000B; rows[3] = 32'h0000000C;
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_row = rows[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (N) tick();
    finish_tile();
    acc = 32'(act_w[0]) * 32'd94;
    checks++;
    if (acc !== 32'd5358) begin
      errors++;
      $display("FAIL e2e_acc: acc=%0d, expected 5358", acc);
    end
    checks++;
    if (act_w[1] !== 8'h0A || act_w[2] !== 8'h0B || act_w[3] !== 8'h0C) begin
      errors++;
      $display("FAIL e2e_rows: %h %h %h, expected 0a 0b 0c", act_w[1], act_w[2], act_w[3]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_reset_mid();
    test_fill_shift();
    test_toggle();
    test_end_to_end();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
